// File: rtl/cfg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cfg_write_arbiter
// Description : Merges register writes from the asynchronous I2C slave
//               outputs and a local clk-domain requester onto one
//               valid/ready write port towards the core register file.
//               I2C select/data are synchronized, qualified for stability,
//               queued in a small FIFO and arbitrated against the local
//               requester. Sticky error flags report malformed selects,
//               FIFO overflow and out-of-range local addresses.
// Optional    : CFG_ARB_RR_EN - when defined, ties are resolved round-robin;
//               otherwise the I2C FIFO has fixed priority.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i2c_data_i/sel_i  - async byte and one-hot register select
//               loc_req_i/addr_i/data_i, loc_gnt_o - local write request
//               wr_valid_o/ready_i/addr_o/data_o/src_o - core write port
//               clr_err_i, err_sel_o/err_ovf_o/err_addr_o - sticky errors
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_write_arbiter #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int NUM_REGS      = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i2c_data_i,
    input  logic [NUM_REGS-1:0] i2c_sel_i,
    input  logic                loc_req_i,
    input  logic [3:0]          loc_addr_i,
    input  logic [7:0]          loc_data_i,
    output logic                loc_gnt_o,
    output logic                wr_valid_o,
    input  logic                wr_ready_i,
    output logic [3:0]          wr_addr_o,
    output logic [7:0]          wr_data_o,
    output logic                wr_src_o,
    input  logic                clr_err_i,
    output logic                err_sel_o,
    output logic                err_ovf_o,
    output logic                err_addr_o
);

    localparam int             c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [3:0]     c_STABLE   = 4'(STABLE_CYCLES);
    localparam logic [4:0]     c_NUM_REGS = 5'(NUM_REGS);
    localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W+1)'(1);

    // ------------------------------------------------------------------
    // Synchronizer and stability qualifier
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] sel_s1_q, sel_s2_q, sel_prev_q;
    logic [7:0]          data_s1_q, data_s2_q, data_prev_q;
    logic [1:0]          warm_q;
    logic [3:0]          cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic                qualify;
    logic                sel_onehot;
    logic [3:0]          sel_idx;

    always_comb begin
        if ({sel_s2_q, data_s2_q} != {sel_prev_q, data_prev_q}) begin
            cnt_d = 4'd0;
        end else if (cnt_q < c_STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // One write per nonzero-select episode: armed only re-arms on an idle select.
    assign qualify    = armed_q && (sel_s2_q != '0) && (cnt_d == c_STABLE) && (cnt_q != c_STABLE);
    assign sel_onehot = $onehot(sel_s2_q);

    always_comb begin
        // warm_q[1] keeps the reset value of the sync flops from arming us,
        // so a select already high when reset drops is ignored.
        if (warm_q[1] && (sel_s2_q == '0)) begin
            armed_d = 1'b1;
        end else if (qualify) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    always_comb begin
        sel_idx = 4'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_s2_q[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            sel_prev_q  <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            data_prev_q <= '0;
            warm_q      <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
        end else begin
            sel_s1_q    <= i2c_sel_i;
            sel_s2_q    <= sel_s1_q;
            sel_prev_q  <= sel_s2_q;
            data_s1_q   <= i2c_data_i;
            data_s2_q   <= data_s1_q;
            data_prev_q <= data_s2_q;
            warm_q      <= {warm_q[0], 1'b1};
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // I2C write FIFO: {addr[3:0], data[7:0]}
    // ------------------------------------------------------------------
    logic [11:0]        fifo_mem_q [FIFO_DEPTH];
    logic [c_PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full;
    logic [11:0]        fifo_head;
    logic               push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[c_PTR_W] != rd_ptr_q[c_PTR_W]) &&
                        (wr_ptr_q[c_PTR_W-1:0] == rd_ptr_q[c_PTR_W-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[c_PTR_W-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = qualify && sel_onehot && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[c_PTR_W-1:0]] <= {sel_idx, data_s2_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic out_free, fifo_cand, loc_cand, fifo_wins;
    logic gnt_fifo, gnt_loc, loc_bad;
    logic last_src_q, last_src_d;

    assign out_free  = !wr_valid_o || wr_ready_i;
    assign fifo_cand = !fifo_empty && out_free;
    assign loc_cand  = loc_req_i && out_free;

`ifdef CFG_ARB_RR_EN
    // Round-robin: the I2C side wins a tie only if local went last.
    assign fifo_wins = last_src_q;
`else
    assign fifo_wins = 1'b1;
`endif

    assign gnt_fifo   = !rst && fifo_cand && (!loc_cand || fifo_wins);
    assign gnt_loc    = !rst && loc_cand && !gnt_fifo;
    assign pop        = gnt_fifo;
    assign loc_bad    = ({1'b0, loc_addr_i} >= c_NUM_REGS);
    assign loc_gnt_o  = gnt_loc;
    assign last_src_d = gnt_fifo ? 1'b0 : (gnt_loc ? 1'b1 : last_src_q);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            wr_src_o   <= 1'b0;
            last_src_q <= 1'b1;
        end else begin
            last_src_q <= last_src_d;
            if (out_free) begin
                if (gnt_fifo) begin
                    wr_valid_o <= 1'b1;
                    wr_addr_o  <= fifo_head[11:8];
                    wr_data_o  <= fifo_head[7:0];
                    wr_src_o   <= 1'b0;
                end else if (gnt_loc && !loc_bad) begin
                    wr_valid_o <= 1'b1;
                    wr_addr_o  <= loc_addr_i;
                    wr_data_o  <= loc_data_i;
                    wr_src_o   <= 1'b1;
                end else begin
                    wr_valid_o <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors: a new event beats a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_o  <= 1'b0;
            err_ovf_o  <= 1'b0;
            err_addr_o <= 1'b0;
        end else begin
            err_sel_o  <= (qualify && !sel_onehot) || (err_sel_o && !clr_err_i);
            err_ovf_o  <= (qualify && sel_onehot && fifo_full && !pop) || (err_ovf_o && !clr_err_i);
            err_addr_o <= (gnt_loc && loc_bad) || (err_addr_o && !clr_err_i);
        end
    end

endmodule
`default_nettype wire
